// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the multi-cycle control unit:
// FSM states, instruction classes, opcode values and instruction field offsets.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEM,
    ST_WRITEBACK,
    ST_HALT
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_JMP,
    CLS_BEQ,
    CLS_HALT,
    CLS_NOP,
    CLS_ILLEGAL
  } instr_class_e;

  localparam int OP_LOAD  = 8;
  localparam int OP_STORE = 9;
  localparam int OP_JMP   = 10;
  localparam int OP_BEQ   = 11;
  localparam int OP_HALT  = 12;
  localparam int OP_NOP   = 13;

  // Instruction layout is [opcode|reg1|reg2|adr], MSB first.
  function automatic int adr_lsb();
    return 0;
  endfunction

  function automatic int reg2_lsb(int adr_w);
    return adr_w;
  endfunction

  function automatic int reg1_lsb(int reg_aw, int adr_w);
    return adr_w + reg_aw;
  endfunction

  function automatic int opc_lsb(int reg_aw, int adr_w);
    return adr_w + 2 * reg_aw;
  endfunction

endpackage

// File: rtl/ctrl_opcode_decoder.sv
// Combinational opcode classifier: everything below OP_LOAD is an ALU op,
// anything not explicitly listed above it is illegal.
module ctrl_opcode_decoder
  import cpu_ctrl_pkg::*;
#(
  parameter int OPC_W = 4
) (
  input  logic [OPC_W-1:0] opcode,
  output instr_class_e     cls
);

  always_comb begin
    cls = CLS_ILLEGAL;
    if (opcode < OPC_W'(OP_LOAD)) begin
      cls = CLS_ALU;
    end else begin
      case (opcode)
        OPC_W'(OP_LOAD):  cls = CLS_LOAD;
        OPC_W'(OP_STORE): cls = CLS_STORE;
        OPC_W'(OP_JMP):   cls = CLS_JMP;
        OPC_W'(OP_BEQ):   cls = CLS_BEQ;
        OPC_W'(OP_HALT):  cls = CLS_HALT;
        OPC_W'(OP_NOP):   cls = CLS_NOP;
        default:          cls = CLS_ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle CPU control unit: fetches into an instruction register and
// sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK, driving datapath strobes.
module multicycle_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int OPC_W  = 4,
  parameter int REG_AW = 2,
  parameter int ADR_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [OPC_W+2*REG_AW+ADR_W-1:0] instr,
  input  logic                            instr_valid,
  output logic                            instr_req,
  input  logic                            zero_flag,
  input  logic                            mem_ready,
  output logic [OPC_W-1:0]                alu_code,
  output logic                            reg_read,
  output logic                            reg_write,
  output logic                            ram_read,
  output logic                            ram_write,
  output logic [REG_AW-1:0]               reg1,
  output logic [REG_AW-1:0]               reg2,
  output logic [ADR_W-1:0]                ram_adr,
  output logic                            pc_inc,
  output logic                            pc_jump,
  output logic                            halted,
  output logic                            illegal,
  output logic [CNT_W-1:0]                retired
);

  localparam int INSTR_W  = OPC_W + 2 * REG_AW + ADR_W;
  localparam int OPC_LSB  = opc_lsb(REG_AW, ADR_W);
  localparam int REG1_LSB = reg1_lsb(REG_AW, ADR_W);
  localparam int REG2_LSB = reg2_lsb(ADR_W);
  localparam int ADR_LSB  = adr_lsb();

  state_e             state, state_next;
  logic [INSTR_W-1:0] ir;
  instr_class_e       cls;
  logic               retire;
  logic               set_illegal;

  ctrl_opcode_decoder #(.OPC_W(OPC_W)) u_decoder (
    .opcode (ir[OPC_LSB +: OPC_W]),
    .cls    (cls)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_FETCH;
      ir      <= '0;
      retired <= '0;
      illegal <= 1'b0;
    end else begin
      state <= state_next;
      if (state == ST_FETCH && instr_valid) ir <= instr;
      if (retire) retired <= retired + CNT_W'(1);
      if (set_illegal) illegal <= 1'b1;
    end
  end

  always_comb begin
    state_next  = state;
    instr_req   = 1'b0;
    alu_code    = '0;
    reg_read    = 1'b0;
    reg_write   = 1'b0;
    ram_read    = 1'b0;
    ram_write   = 1'b0;
    reg1        = '0;
    reg2        = '0;
    ram_adr     = '0;
    pc_inc      = 1'b0;
    pc_jump     = 1'b0;
    halted      = 1'b0;
    retire      = 1'b0;
    set_illegal = 1'b0;

    // Reset forces every output low, including the FETCH request.
    if (!rst) begin
      if (state != ST_FETCH) begin
        reg1    = ir[REG1_LSB +: REG_AW];
        reg2    = ir[REG2_LSB +: REG_AW];
        ram_adr = ir[ADR_LSB +: ADR_W];
      end

      case (state)
        ST_FETCH: begin
          instr_req = 1'b1;
          if (instr_valid) state_next = ST_DECODE;
        end
        ST_DECODE: begin
          reg_read   = (cls == CLS_ALU) || (cls == CLS_STORE);
          state_next = ST_EXECUTE;
        end
        ST_EXECUTE: begin
          case (cls)
            CLS_ALU: begin
              alu_code   = ir[OPC_LSB +: OPC_W];
              state_next = ST_WRITEBACK;
            end
            CLS_LOAD, CLS_STORE: state_next = ST_MEM;
            CLS_JMP: begin
              pc_jump    = 1'b1;
              retire     = 1'b1;
              state_next = ST_FETCH;
            end
            CLS_BEQ: begin
              pc_jump    = zero_flag;
              pc_inc     = !zero_flag;
              retire     = 1'b1;
              state_next = ST_FETCH;
            end
            CLS_HALT: begin
              retire     = 1'b1;
              state_next = ST_HALT;
            end
            CLS_NOP: begin
              pc_inc     = 1'b1;
              retire     = 1'b1;
              state_next = ST_FETCH;
            end
            default: begin
              set_illegal = 1'b1;
              pc_inc      = 1'b1;
              retire      = 1'b1;
              state_next  = ST_FETCH;
            end
          endcase
        end
        ST_MEM: begin
          ram_read  = (cls == CLS_LOAD);
          ram_write = (cls != CLS_LOAD);
          if (mem_ready) begin
            if (cls == CLS_LOAD) begin
              state_next = ST_WRITEBACK;
            end else begin
              pc_inc     = 1'b1;
              retire     = 1'b1;
              state_next = ST_FETCH;
            end
          end
        end
        ST_WRITEBACK: begin
          reg_write  = 1'b1;
          pc_inc     = 1'b1;
          retire     = 1'b1;
          state_next = ST_FETCH;
        end
        ST_HALT: halted = 1'b1;
        default: state_next = ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed-vector bench for multicycle_control_unit with hand-computed expectations.
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_req;
  logic        zero_flag;
  logic        mem_ready;
  logic [3:0]  alu_code;
  logic        reg_read, reg_write, ram_read, ram_write;
  logic [1:0]  reg1, reg2;
  logic [7:0]  ram_adr;
  logic        pc_inc, pc_jump, halted, illegal;
  logic [15:0] retired;

  int vectors = 0;
  int miscompares = 0;

  multicycle_control_unit dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_req   (instr_req),
    .zero_flag   (zero_flag),
    .mem_ready   (mem_ready),
    .alu_code    (alu_code),
    .reg_read    (reg_read),
    .reg_write   (reg_write),
    .ram_read    (ram_read),
    .ram_write   (ram_write),
    .reg1        (reg1),
    .reg2        (reg2),
    .ram_adr     (ram_adr),
    .pc_inc      (pc_inc),
    .pc_jump     (pc_jump),
    .halted      (halted),
    .illegal     (illegal),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Called in a FETCH cycle; leaves the bench in the following DECODE cycle.
  task automatic issue(input logic [15:0] w);
    instr       = w;
    instr_valid = 1'b1;
    #1;
    chk("fetch_req", instr_req, 1);
    chk("fetch_adr", ram_adr, 0);
    cyc();
    instr_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; instr = '0; instr_valid = 1'b0; zero_flag = 1'b0; mem_ready = 1'b0;
    cyc(); cyc();
    chk("rst_req", instr_req, 0);
    chk("rst_retired", retired, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_halted", halted, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_req", instr_req, 1);

    // ALU op 4, reg1=3, reg2=1
    issue(16'h4D00);
    instr_valid = 1'b1;
    #1;
    chk("alu_dec_rd", reg_read, 1);
    chk("alu_dec_r1", reg1, 3);
    chk("alu_dec_r2", reg2, 1);
    chk("alu_dec_code", alu_code, 0);
    cyc(); #1;
    chk("alu_ex_code", alu_code, 4'h4);
    chk("alu_ex_rd", reg_read, 0);
    chk("alu_ex_inc", pc_inc, 0);
    cyc(); #1;
    chk("alu_wb_wr", reg_write, 1);
    chk("alu_wb_inc", pc_inc, 1);
    chk("alu_wb_ret", retired, 0);
    cyc(); instr_valid = 1'b0; #1;
    chk("alu_ret", retired, 1);
    chk("alu_req", instr_req, 1);

    // LOAD r2 <- [0x42], three wait cycles
    issue(16'h8A42);
    #1;
    chk("ld_dec_rd", reg_read, 0);
    chk("ld_dec_adr", ram_adr, 8'h42);
    cyc(); #1;
    chk("ld_ex_rr", ram_read, 0);
    chk("ld_ex_inc", pc_inc, 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      mem_ready = (i == 3);
      #1;
      chk("ld_mem_rr", ram_read, 1);
      chk("ld_mem_adr", ram_adr, 8'h42);
      chk("ld_mem_inc", pc_inc, 0);
    end
    cyc(); mem_ready = 1'b0; #1;
    chk("ld_wb_rr", ram_read, 0);
    chk("ld_wb_wr", reg_write, 1);
    chk("ld_wb_inc", pc_inc, 1);
    chk("ld_wb_r1", reg1, 2);
    cyc(); #1;
    chk("ld_ret", retired, 2);

    // STORE r1 -> [0x33], no wait
    issue(16'h9433);
    #1;
    chk("st_dec_rd", reg_read, 1);
    cyc(); cyc(); mem_ready = 1'b1; #1;
    chk("st_mem_wr", ram_write, 1);
    chk("st_mem_rr", ram_read, 0);
    chk("st_mem_inc", pc_inc, 1);
    chk("st_mem_adr", ram_adr, 8'h33);
    cyc(); mem_ready = 1'b0; #1;
    chk("st_ret", retired, 3);

    // BEQ taken
    issue(16'hB010);
    #1;
    chk("beq_dec_rd", reg_read, 0);
    cyc(); zero_flag = 1'b1; #1;
    chk("beq_t_jump", pc_jump, 1);
    chk("beq_t_inc", pc_inc, 0);
    chk("beq_t_adr", ram_adr, 8'h10);
    cyc(); zero_flag = 1'b0; #1;
    chk("beq_t_ret", retired, 4);

    // BEQ not taken
    issue(16'hB010);
    cyc(); #1;
    chk("beq_n_jump", pc_jump, 0);
    chk("beq_n_inc", pc_inc, 1);
    cyc(); #1;
    chk("beq_n_ret", retired, 5);

    // JMP 0x77
    issue(16'hA077);
    cyc(); #1;
    chk("jmp_jump", pc_jump, 1);
    chk("jmp_inc", pc_inc, 0);
    chk("jmp_adr", ram_adr, 8'h77);
    cyc(); #1;
    chk("jmp_ret", retired, 6);

    // NOP
    issue(16'hD000);
    cyc(); #1;
    chk("nop_inc", pc_inc, 1);
    chk("nop_jump", pc_jump, 0);
    cyc(); #1;
    chk("nop_ret", retired, 7);

    // Illegal opcode 0xE
    issue(16'hE000);
    cyc(); #1;
    chk("ill_inc", pc_inc, 1);
    chk("ill_flag_ex", illegal, 0);
    cyc(); #1;
    chk("ill_flag", illegal, 1);
    chk("ill_ret", retired, 8);

    // Following ALU op keeps the illegal flag set
    issue(16'h1500);
    cyc(); #1;
    chk("alu2_code", alu_code, 4'h1);
    cyc(); cyc(); #1;
    chk("alu2_illegal", illegal, 1);
    chk("alu2_ret", retired, 9);

    // Reset while a LOAD is stalled in MEM
    issue(16'h8A42);
    cyc(); cyc(); #1;
    chk("rmem_rr", ram_read, 1);
    rst = 1'b1;
    #1;
    chk("rmem_rr_drop", ram_read, 0);
    chk("rmem_req", instr_req, 0);
    chk("rmem_ret", retired, 0);
    chk("rmem_ill", illegal, 0);
    cyc();
    rst = 1'b0;
    #1;
    chk("rmem_req_rel", instr_req, 1);
    chk("rmem_ret_rel", retired, 0);

    // HALT: only reset exits, fetch requests stop
    issue(16'hC000);
    cyc(); #1;
    chk("halt_ex_h", halted, 0);
    instr_valid = 1'b1;
    cyc(); #1;
    chk("halt_h", halted, 1);
    chk("halt_ret", retired, 1);
    for (int i = 0; i < 20; i++) begin
      cyc(); #1;
      chk("halt_req", instr_req, 0);
      chk("halt_ret_hold", retired, 1);
      chk("halt_inc", pc_inc, 0);
    end
    chk("halt_h_end", halted, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
